// File: rtl/ei_tdp_ram_pipe_if.sv
// ei_tdp_ram_pipe_if: dual-port request/response bundle for ei_tdp_ram_pipe.
interface ei_tdp_ram_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    logic                  en_a, we_a, rvalid_a;
    logic [NB-1:0]         be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] wdata_a, rdata_a;
    logic                  en_b, we_b, rvalid_b;
    logic [NB-1:0]         be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] wdata_b, rdata_b;
    logic                  ready, collision;
    modport master (
        output en_a, we_a, be_a, addr_a, wdata_a, en_b, we_b, be_b, addr_b, wdata_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b, ready, collision
    );
    modport slave (
        input  en_a, we_a, be_a, addr_a, wdata_a, en_b, we_b, be_b, addr_b, wdata_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b, ready, collision
    );
endinterface

// File: rtl/ei_tdp_ram_pipe.sv
// ei_tdp_ram_pipe: true dual-port RAM with byte enables, pipelined reads, collision arbitration and clear-on-reset.
module ei_tdp_ram_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int PRIO_B     = 0
) (
    input logic clk,
    input logic resetn,
    ei_tdp_ram_pipe_if.slave bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WIN   = PRIO_B != 0 ? 1 : 0;
    localparam int LOSE  = 1 - WIN;
    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 3 || DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_param
            $error("ei_tdp_ram_pipe: illegal RD_LATENCY or DATA_WIDTH/BYTE_WIDTH");
        end
    endgenerate
    typedef enum logic {INIT, READY} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready_q, collision_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            acc, wr;
    logic [NB-1:0]         be [2];
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    always_comb begin
        acc      = {bus.en_b, bus.en_a} & {2{ready_q}};
        wr       = acc & {bus.we_b, bus.we_a};
        be[0]    = bus.be_a;
        be[1]    = bus.be_b;
        addr[0]  = bus.addr_a;
        addr[1]  = bus.addr_b;
        wdata[0] = bus.wdata_a;
        wdata[1] = bus.wdata_b;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state       <= INIT;
            cnt         <= '0;
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state   <= READY;
                    ready_q <= 1'b1;
                end
            end
        end
    // Loser's lanes are written first so the winner's later assignment takes the shared lanes.
    always_ff @(posedge clk) begin
        if (!ready_q) mem[cnt] <= '0;
        for (int k = 0; k < NB; k++) begin
            if (wr[LOSE] && be[LOSE][k]) mem[addr[LOSE]][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[LOSE][k*BYTE_WIDTH +: BYTE_WIDTH];
            if (wr[WIN] && be[WIN][k]) mem[addr[WIN]][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[WIN][k*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end
    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [DATA_WIDTH-1:0] old, mrg, rd;
            logic [RD_LATENCY-1:0] pv;
            logic [DATA_WIDTH-1:0] pd [RD_LATENCY];
            // Cross-port writes never show up here: old is the pre-edge array word.
            always_comb begin
                old = mem[addr[p]];
                mrg = old;
                for (int k = 0; k < NB; k++)
                    mrg[k*BYTE_WIDTH +: BYTE_WIDTH] = be[p][k] ? wdata[p][k*BYTE_WIDTH +: BYTE_WIDTH] : old[k*BYTE_WIDTH +: BYTE_WIDTH];
                rd = (RDW_MODE != 0 && wr[p]) ? mrg : old;
            end
            always_ff @(posedge clk or negedge resetn)
                if (!resetn) begin
                    pv <= '0;
                    for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
                end else begin
                    pv[0] <= acc[p];
                    if (acc[p]) pd[0] <= rd;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        pv[i] <= pv[i-1];
                        if (pv[i-1]) pd[i] <= pd[i-1];
                    end
                end
        end
    endgenerate
    assign bus.rdata_a   = g_port[0].pd[RD_LATENCY-1];
    assign bus.rvalid_a  = g_port[0].pv[RD_LATENCY-1];
    assign bus.rdata_b   = g_port[1].pd[RD_LATENCY-1];
    assign bus.rvalid_b  = g_port[1].pv[RD_LATENCY-1];
    assign bus.ready     = ready_q;
    assign bus.collision = collision_q;
endmodule

// File: tb/tb_ei_tdp_ram_pipe.sv
// tb_ei_tdp_ram_pipe: two DUTs (latency 1 read-first A-priority, latency 3 write-first B-priority) on shared directed stimulus.
module tb_ei_tdp_ram_pipe;
    logic clk = 1'b0, resetn = 1'b0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    ei_tdp_ram_pipe_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
    ei_tdp_ram_pipe_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();
    ei_tdp_ram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0), .PRIO_B(0))
        dut0 (.clk(clk), .resetn(resetn), .bus(bus0.slave));
    ei_tdp_ram_pipe #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .RD_LATENCY(3), .RDW_MODE(1), .PRIO_B(1))
        dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));
    typedef struct {
        logic ea, wa; logic [3:0] ba, aa; logic [31:0] da;
        logic eb, wb; logic [3:0] bb, ab; logic [31:0] db;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic col, d1;
    } vec_t;
    typedef struct packed {logic rva, rvb; logic [31:0] rda, rdb; logic col, rdy;} obs_t;
    vec_t vt [17];
    logic [31:0] exp_mem [16];
    function automatic obs_t obs(input int d);
        return d == 0 ? {bus0.rvalid_a, bus0.rvalid_b, bus0.rdata_a, bus0.rdata_b, bus0.collision, bus0.ready}
                      : {bus1.rvalid_a, bus1.rvalid_b, bus1.rdata_a, bus1.rdata_b, bus1.collision, bus1.ready};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic drv(input vec_t v);
        {bus0.en_a, bus0.we_a, bus0.be_a, bus0.addr_a, bus0.wdata_a} = {v.ea, v.wa, v.ba, v.aa, v.da};
        {bus0.en_b, bus0.we_b, bus0.be_b, bus0.addr_b, bus0.wdata_b} = {v.eb, v.wb, v.bb, v.ab, v.db};
        {bus1.en_a, bus1.we_a, bus1.be_a, bus1.addr_a, bus1.wdata_a} = {v.ea, v.wa, v.ba, v.aa, v.da};
        {bus1.en_b, bus1.we_b, bus1.be_b, bus1.addr_b, bus1.wdata_b} = {v.eb, v.wb, v.bb, v.ab, v.db};
    endtask
    task automatic idle();
        vec_t v = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
        drv(v);
    endtask
    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            obs_t o = obs(d);
            chk($sformatf("%s d%0d ready", tag, d), 32'(o.rdy), 32'h0);
            chk($sformatf("%s d%0d collision", tag, d), 32'(o.col), 32'h0);
            chk($sformatf("%s d%0d rvalid_a", tag, d), 32'(o.rva), 32'h0);
            chk($sformatf("%s d%0d rvalid_b", tag, d), 32'(o.rvb), 32'h0);
            chk($sformatf("%s d%0d rdata_a", tag, d), o.rda, 32'h0);
            chk($sformatf("%s d%0d rdata_b", tag, d), o.rdb, 32'h0);
        end
    endtask
    // Counts INIT edges; ready must rise only on the 16th, and no request may produce rvalid meanwhile.
    task automatic init_edges(input int n);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                obs_t o = obs(d);
                chk($sformatf("init e%0d d%0d ready", e, d), 32'(o.rdy), 32'(e == 16));
                chk($sformatf("init e%0d d%0d rvalid", e, d), 32'({o.rva, o.rvb}), 32'h0);
                chk($sformatf("init e%0d d%0d collision", e, d), 32'(o.col), 32'h0);
            end
            if (e == 16) idle();
        end
    endtask
    task automatic run_vec(input int i);
        vec_t v = vt[i];
        @(negedge clk);
        drv(v);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                obs_t o = obs(d);
                int l = d == 0 ? 1 : 3;
                chk($sformatf("v%0d c%0d d%0d rvalid_a", i, c, d), 32'(o.rva), 32'(v.ea && c == l));
                chk($sformatf("v%0d c%0d d%0d rvalid_b", i, c, d), 32'(o.rvb), 32'(v.eb && c == l));
                chk($sformatf("v%0d c%0d d%0d collision", i, c, d), 32'(o.col), 32'(c == 1 && v.col));
                if (c >= l && (d == 0 || v.d1)) begin
                    if (v.ea) chk($sformatf("v%0d c%0d d%0d rdata_a", i, c, d), o.rda, d == 0 ? v.ra0 : v.ra1);
                    if (v.eb) chk($sformatf("v%0d c%0d d%0d rdata_b", i, c, d), o.rdb, d == 0 ? v.rb0 : v.rb1);
                end
            end
            if (c == 1) idle();
        end
    endtask
    task automatic stream(input int n);
        @(negedge clk);
        {bus0.en_a, bus0.addr_a, bus1.en_a, bus1.addr_a} = {1'b1, 4'h0, 1'b1, 4'h0};
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                obs_t o = obs(d);
                int k = c - (d == 0 ? 1 : 3);
                logic v = k >= 0 && k < n;
                chk($sformatf("stream c%0d d%0d rvalid_a", c, d), 32'(o.rva), 32'(v));
                chk($sformatf("stream c%0d d%0d rvalid_b", c, d), 32'(o.rvb), 32'h0);
                if (v) chk($sformatf("stream c%0d d%0d rdata_a", c, d), o.rda, exp_mem[k]);
            end
            if (c < n) {bus0.addr_a, bus1.addr_a} = {4'(c), 4'(c)};
            else idle();
        end
    endtask
    initial begin
        vt[0]  = '{1'b1, 1'b0, 4'h0, 4'hF, 32'h0,        1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
        vt[1]  = '{1'b1, 1'b1, 4'h5, 4'h3, 32'hAABBCCDD, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h00BB00DD, 32'h0,        1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 4'h3, 32'h0,        32'h0,        32'h00BB00DD, 32'h0,        32'h00BB00DD, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 1'b1, 4'hF, 4'h7, 32'h12345678, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h12345678, 32'h0,        1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 4'hF, 4'h7, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0, 4'h7, 32'h0,        32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 4'h0, 4'h7, 32'h0,        1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 4'hF, 4'h5, 32'h11111111, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h11111111, 32'h0,        1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 4'h3, 4'h5, 32'hAAAAAAAA, 1'b1, 1'b1, 4'h6, 4'h5, 32'hBBBBBBBB, 32'h11111111, 32'h11111111, 32'h0,        32'h0,        1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 4'h0, 4'h5, 32'h0,        1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h11BBAAAA, 32'h0,        32'h11BBBBAA, 32'h0,        1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 4'hF, 4'h5, 32'h11111111, 32'h0,        32'h11BBAAAA, 32'h0,        32'h11111111, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b1, 4'h3, 4'h5, 32'hAAAAAAAA, 1'b1, 1'b1, 4'hC, 4'h5, 32'hBBBBBBBB, 32'h11111111, 32'h11111111, 32'h0,        32'h0,        1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 4'h0, 4'h5, 32'h0,        32'h0,        32'hBBBBAAAA, 32'h0,        32'hBBBBAAAA, 1'b0, 1'b1};
        vt[12] = '{1'b1, 1'b1, 4'hF, 4'h1, 32'h01010101, 1'b1, 1'b1, 4'h8, 4'h2, 32'h02FFFFFF, 32'h0,        32'h0,        32'h01010101, 32'h02000000, 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b0, 4'h0, 4'h2, 32'h0,        1'b1, 1'b0, 4'h0, 4'h1, 32'h0,        32'h02000000, 32'h01010101, 32'h02000000, 32'h01010101, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 4'h0, 4'h6, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
        vt[15] = '{1'b1, 1'b0, 4'h0, 4'h6, 32'h0,        1'b0, 1'b0, 4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
        vt[16] = '{1'b1, 1'b0, 4'h0, 4'h3, 32'h0,        1'b1, 1'b1, 4'hF, 4'h3, 32'h55555555, 32'h00BB00DD, 32'h00BB00DD, 32'h00BB00DD, 32'h55555555, 1'b0, 1'b1};
        idle();
        repeat (2) @(negedge clk);
        chk_zero("por");
        resetn = 1'b1;
        init_edges(9);
        #2 resetn = 1'b0;
        #1 chk_zero("rst_init");
        @(negedge clk);
        resetn = 1'b1;
        init_edges(16);
        for (int i = 0; i < 17; i++) run_vec(i);
        exp_mem = '{32'h0, 32'h01010101, 32'h02000000, 32'h55555555, 32'h0, 32'hBBBBAAAA, 32'h0, 32'hCAFEF00D,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        stream(8);
        @(negedge clk);
        {bus0.en_a, bus0.addr_a, bus1.en_a, bus1.addr_a} = {1'b1, 4'h5, 1'b1, 4'h5};
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1 chk_zero("rst_burst");
        idle();
        @(negedge clk);
        resetn = 1'b1;
        {bus0.en_a, bus0.we_a, bus0.be_a, bus0.wdata_a, bus0.en_b} = {1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1};
        {bus1.en_a, bus1.we_a, bus1.be_a, bus1.wdata_a, bus1.en_b} = {1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1};
        init_edges(16);
        foreach (exp_mem[i]) exp_mem[i] = 32'h0;
        stream(16);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
